spi_ram_arbiter: RTL

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_ram_arbiter.sv
// Two-requester round-robin arbiter driving a serial SPI RAM with 64-bit mode-0 frames (optional init frame: SPIRAM_ARB_INIT_EN).
// Latency: grant-to-ack = 128*CLK_DIV clk cycles, then GAP_CYC cycles of cs_n high before the next grant.
// Backpressure: requesters hold req until their one-cycle ack; no grant is made while a frame or gap is running.
module spi_ram_arbiter #(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [23:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [23:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        spi_cs_n_ram,
    output logic        spi_clk_ram,
    output logic        spi_mosi_ram,
    input  logic        spi_miso_ram
);

`ifdef SPIRAM_ARB_INIT_EN
    localparam logic [1:0] ST_INIT  = 2'd0;
`endif
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;
`ifdef SPIRAM_ARB_INIT_EN
    localparam logic [1:0] ST_RESET = ST_INIT;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    logic [1:0]  state;
    logic [3:0]  div_cnt;
    logic [3:0]  gap_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  last_bit;
    logic [63:0] tx_sr;
    logic [31:0] rx_sr;
    logic        cur_we;
    logic        cur_m1;
    logic        last_m1;
    logic        init_frame;
    logic        cs_n_q;
    logic        sclk_q;
    logic        ack0_q;
    logic        ack1_q;
    logic [31:0] rdata_q;

    logic        pick_m1;
    logic        g_we;
    logic [23:0] g_addr;
    logic [31:0] g_wdata;

    // Data bytes travel little-endian: word[7:0] first on the wire.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_comb begin
        pick_m1 = m1_req && (!m0_req || !last_m1);
        g_we    = pick_m1 ? m1_we    : m0_we;
        g_addr  = pick_m1 ? m1_addr  : m0_addr;
        g_wdata = pick_m1 ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RESET;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            last_bit   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            cur_we     <= 1'b0;
            cur_m1     <= 1'b0;
            last_m1    <= 1'b1;
            init_frame <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
`ifdef SPIRAM_ARB_INIT_EN
                ST_INIT: begin
                    cs_n_q     <= 1'b0;
                    tx_sr      <= {16'h0140, 48'h0};
                    last_bit   <= 6'd15;
                    init_frame <= 1'b1;
                    bit_cnt    <= '0;
                    div_cnt    <= '0;
                    state      <= ST_SHIFT;
                end
`endif
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        cs_n_q     <= 1'b0;
                        tx_sr      <= {g_we ? 8'h02 : 8'h03, g_addr,
                                       g_we ? swap_bytes(g_wdata) : 32'h0};
                        cur_we     <= g_we;
                        cur_m1     <= pick_m1;
                        last_m1    <= pick_m1;
                        last_bit   <= 6'd63;
                        init_frame <= 1'b0;
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_sr  <= {rx_sr[30:0], spi_miso_ram};
                        end else begin
                            // Falling SCLK edge: advance MOSI, or close the frame after the last bit.
                            sclk_q <= 1'b0;
                            tx_sr  <= {tx_sr[62:0], 1'b0};
                            if (bit_cnt == last_bit) begin
                                cs_n_q  <= 1'b1;
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                                if (!init_frame) begin
                                    ack0_q <= !cur_m1;
                                    ack1_q <= cur_m1;
                                    if (!cur_we) rdata_q <= swap_bytes(rx_sr);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= ST_IDLE;
                    else gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m0_ack       = ack0_q;
    assign m1_ack       = ack1_q;
    assign rdata        = rdata_q;
    assign busy         = (state != ST_IDLE);
    assign spi_cs_n_ram = cs_n_q;
    assign spi_clk_ram  = sclk_q;
    assign spi_mosi_ram = tx_sr[63];

endmodule
